// File: rtl/spi_sif_pkg.sv
// rtl/spi_sif_pkg.sv - shared types and frame constants for the SPI register bridge
// Contents: FSM state enum, command-field bit positions, small helper function.
package spi_sif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD
  } sif_state_t;

  // Command field: first bit on the wire is RNW (1=write), second is BURST.
  localparam int C_RNW_POS   = 0;
  localparam int C_BURST_POS = 1;
  localparam int C_CMD_BITS  = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sif_sync.sv
// rtl/spi_sif_sync.sv - SPI pin synchroniser and SCL edge detector
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   csn_in/scl_in/sdi_in  raw SPI pins
//   csn                synchronised chip select level
//   sdi                synchronised data in, valid on smp_edge
//   csn_fall           one-cycle pulse on chip select assertion
//   smp_edge           one-cycle pulse on SCL leading (sample) edge
//   lch_edge           one-cycle pulse on SCL trailing (launch) edge
module spi_sif_sync #(
  parameter int P_CPOL = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic csn_in,
  input  logic scl_in,
  input  logic sdi_in,
  output logic csn,
  output logic sdi,
  output logic csn_fall,
  output logic smp_edge,
  output logic lch_edge
);

  localparam logic C_IDLE = (P_CPOL != 0);

  // Bit order in every stage: {csn, scl, sdi}
  logic [2:0] in_q;
  logic [2:0] sh1;
  logic [2:0] sh2;
  logic       scl_chg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_q <= '0;
      sh1  <= '0;
      sh2  <= '0;
    end else begin
      in_q <= {csn_in, scl_in, sdi_in};
      sh1  <= in_q;
      sh2  <= sh1;
    end
  end

  assign csn      = sh1[2];
  assign csn_fall = sh2[2] & ~sh1[2];
  assign scl_chg  = sh1[1] ^ sh2[1];
  // Leading edge leaves the idle level, trailing edge returns to it.
  assign smp_edge = scl_chg && (sh1[1] != C_IDLE);
  assign lch_edge = scl_chg && (sh1[1] == C_IDLE);
  // Older stage: SDI as it stood just before SCL moved.
  assign sdi      = sh2[0];

endmodule

// File: rtl/spi_burst_sif.sv
// rtl/spi_burst_sif.sv - SPI slave to register-bus bridge with burst read/write
// Optional feature macro: SPI_BURST_SIF_TOUT_EN (read-wait timeout)
// Ports:
//   CLK, RST                          clock, synchronous active-high reset
//   REG_WREN/REG_WADR/REG_WDAT        register write strobe, address, data
//   REG_RDEN/REG_RADR                 register read strobe, address
//   REG_RDAT/REG_RVLD                 register read data and its valid
//   SPI_CSN/SPI_SCL/SPI_SDI           SPI inputs
//   SPI_SDO/SPI_SDO_OE                SPI data out and its drive enable
//   RD_TOUT                           read timeout pulse
module spi_burst_sif
  import spi_sif_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 16,
  parameter int P_CPOL       = 0,
  parameter int P_RD_TOUT    = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    REG_WREN,
  output logic [P_ADDR_WIDTH-1:0] REG_WADR,
  output logic [P_DATA_WIDTH-1:0] REG_WDAT,
  output logic                    REG_RDEN,
  output logic [P_ADDR_WIDTH-1:0] REG_RADR,
  input  logic [P_DATA_WIDTH-1:0] REG_RDAT,
  input  logic                    REG_RVLD,
  input  logic                    SPI_CSN,
  input  logic                    SPI_SCL,
  input  logic                    SPI_SDI,
  output logic                    SPI_SDO,
  output logic                    SPI_SDO_OE,
  output logic                    RD_TOUT
);

  localparam int AW  = P_ADDR_WIDTH;
  localparam int DW  = P_DATA_WIDTH;
  localparam int AW1 = AW - 1;
  localparam int DW1 = DW - 1;
  localparam int CW  = $clog2(max2(max2(AW, DW), C_CMD_BITS));

  logic csn_s, sdi_s, csn_fall, smp_edge, lch_edge;

  spi_sif_sync #(.P_CPOL(P_CPOL)) u_sync (
    .CLK      (CLK),
    .RST      (RST),
    .csn_in   (SPI_CSN),
    .scl_in   (SPI_SCL),
    .sdi_in   (SPI_SDI),
    .csn      (csn_s),
    .sdi      (sdi_s),
    .csn_fall (csn_fall),
    .smp_edge (smp_edge),
    .lch_edge (lch_edge)
  );

  sif_state_t    state, state_nxt;
  logic [CW-1:0] bit_cnt;
  logic          rnw, burst;
  logic [AW1-1:0] addr_sr;
  logic [DW1-1:0] data_sr;
  logic [AW-1:0] word_addr;
  logic [DW-1:0] rd_buf;   // load stage for the SDO shifter, filled by RVLD
  logic [DW-1:0] sdo_sr;
  logic          rd_pend;
  logic          rd_acc;
  logic          smp_ok, last_cmd, last_addr, last_data;

  assign smp_ok    = smp_edge && !csn_s;
  assign last_cmd  = (bit_cnt == CW'(C_CMD_BITS - 1));
  assign last_addr = (bit_cnt == CW'(AW - 1));
  assign last_data = (bit_cnt == CW'(DW - 1));
  assign rd_acc    = REG_RVLD && rd_pend;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (csn_fall) state_nxt = ST_CMD;
      ST_CMD:  if (smp_ok && last_cmd) state_nxt = ST_ADDR;
      ST_ADDR: if (smp_ok && last_addr) state_nxt = ST_DATA;
      ST_DATA: if (smp_ok && last_data && !burst) state_nxt = ST_HOLD;
      ST_HOLD: state_nxt = ST_HOLD;
      default: state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && csn_s) state_nxt = ST_IDLE;
  end

  // Frame decode and register strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt   <= '0;
      rnw       <= 1'b0;
      burst     <= 1'b0;
      addr_sr   <= '0;
      data_sr   <= '0;
      word_addr <= '0;
      REG_WREN  <= 1'b0;
      REG_WADR  <= '0;
      REG_WDAT  <= '0;
      REG_RDEN  <= 1'b0;
      REG_RADR  <= '0;
    end else begin
      REG_WREN <= 1'b0;
      REG_RDEN <= 1'b0;
      if (state == ST_IDLE) begin
        bit_cnt <= '0;
        rnw     <= 1'b0;
        burst   <= 1'b0;
      end else if (smp_ok) begin
        case (state)
          ST_CMD: begin
            if (bit_cnt == CW'(C_RNW_POS)) rnw <= sdi_s;
            if (bit_cnt == CW'(C_BURST_POS)) burst <= sdi_s;
            bit_cnt <= last_cmd ? '0 : bit_cnt + CW'(1);
          end
          ST_ADDR: begin
            addr_sr <= AW1'({addr_sr, sdi_s});
            if (last_addr) begin
              bit_cnt   <= '0;
              word_addr <= {addr_sr, sdi_s};
              if (!rnw) begin
                REG_RDEN <= 1'b1;
                REG_RADR <= {addr_sr, sdi_s};
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          ST_DATA: begin
            data_sr <= DW1'({data_sr, sdi_s});
            // First bit of a burst read word: prefetch the following word.
            if (!rnw && burst && bit_cnt == '0) begin
              REG_RDEN <= 1'b1;
              REG_RADR <= word_addr + AW'(1);
            end
            if (last_data) begin
              bit_cnt   <= '0;
              word_addr <= word_addr + AW'(1);
              if (rnw) begin
                REG_WREN <= 1'b1;
                REG_WADR <= word_addr;
                REG_WDAT <= {data_sr, sdi_s};
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_BURST_SIF_TOUT_EN
  localparam int TW = $clog2(P_RD_TOUT + 1);
  logic [TW-1:0] tout_cnt;
  logic          rd_tout_q;
  assign RD_TOUT = rd_tout_q;
`else
  assign RD_TOUT = 1'b0;
`endif

  // Read data path: RVLD fills rd_buf; rd_buf moves into the shifter at
  // the launch edge that starts a word, so a prefetch never disturbs the
  // word currently on the wire.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend    <= 1'b0;
      rd_buf     <= '0;
      sdo_sr     <= '0;
      SPI_SDO    <= 1'b0;
      SPI_SDO_OE <= 1'b0;
`ifdef SPI_BURST_SIF_TOUT_EN
      tout_cnt   <= '0;
      rd_tout_q  <= 1'b0;
`endif
    end else begin
      SPI_SDO_OE <= (state_nxt == ST_DATA) && !rnw;
`ifdef SPI_BURST_SIF_TOUT_EN
      rd_tout_q <= 1'b0;
`endif
      if (state == ST_IDLE) begin
        rd_pend <= 1'b0;
        rd_buf  <= '0;
        sdo_sr  <= '0;
        SPI_SDO <= 1'b0;
      end else begin
        // A same-cycle RVLD belongs to the older read; the new one stays pending.
        rd_pend <= (rd_pend && !REG_RVLD) || REG_RDEN;
        if (lch_edge && !csn_s && state == ST_DATA && !rnw) begin
          if (bit_cnt == '0) begin
            SPI_SDO <= rd_buf[DW-1];
            sdo_sr  <= rd_buf << 1;
            rd_buf  <= '0;
          end else begin
            SPI_SDO <= sdo_sr[DW-1];
            sdo_sr  <= sdo_sr << 1;
          end
        end
        if (rd_acc) rd_buf <= REG_RDAT;
`ifdef SPI_BURST_SIF_TOUT_EN
        if (REG_RDEN) begin
          tout_cnt <= TW'(1);
        end else if (rd_pend && !REG_RVLD) begin
          if (tout_cnt == TW'(P_RD_TOUT - 1)) begin
            tout_cnt  <= '0;
            rd_tout_q <= 1'b1;
            rd_buf    <= '1;
            rd_pend   <= 1'b0;
          end else begin
            tout_cnt <= tout_cnt + TW'(1);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_sif.sv
// tb/tb_spi_burst_sif.sv - directed self-checking bench for spi_burst_sif
// dut0 runs with P_CPOL=0, dut1 with P_CPOL=1 on the inverted clock line.
module tb_spi_burst_sif;
  import spi_sif_pkg::*;

  localparam int H = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csn = 1'b1, scl = 1'b0, sdi = 1'b0, scl_n;
  logic [15:0] rdat = '0;
  logic        rvld = 1'b0;
  logic        resp_en = 1'b1;

  logic        wren0, rden0, sdo0, oe0, tout0;
  logic [7:0]  wadr0, radr0;
  logic [15:0] wdat0;
  logic        wren1, rden1, sdo1, oe1, tout1;
  logic [7:0]  wadr1, radr1;
  logic [15:0] wdat1;

  int checks = 0, errors = 0;
  int cyc = 0, last_rden_cyc = 0, tout_n = 0, tout_delta = 0;
  int wa0q[$], wd0q[$], wa1q[$], ra0q[$], ra1q[$], dueq[$];
  logic [15:0] rdq[$];
  logic [63:0] rx0, rx1, oel0, oel1;

  assign scl_n = ~scl;
  always #5 clk = ~clk;

  spi_burst_sif #(.P_CPOL(0)) dut0 (
    .CLK(clk), .RST(rst),
    .REG_WREN(wren0), .REG_WADR(wadr0), .REG_WDAT(wdat0),
    .REG_RDEN(rden0), .REG_RADR(radr0), .REG_RDAT(rdat), .REG_RVLD(rvld),
    .SPI_CSN(csn), .SPI_SCL(scl), .SPI_SDI(sdi),
    .SPI_SDO(sdo0), .SPI_SDO_OE(oe0), .RD_TOUT(tout0)
  );

  spi_burst_sif #(.P_CPOL(1)) dut1 (
    .CLK(clk), .RST(rst),
    .REG_WREN(wren1), .REG_WADR(wadr1), .REG_WDAT(wdat1),
    .REG_RDEN(rden1), .REG_RADR(radr1), .REG_RDAT(rdat), .REG_RVLD(rvld),
    .SPI_CSN(csn), .SPI_SCL(scl_n), .SPI_SDI(sdi),
    .SPI_SDO(sdo1), .SPI_SDO_OE(oe1), .RD_TOUT(tout1)
  );

  // Bus monitor and register-side responder (RVLD two cycles after RDEN)
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rvld = 1'b0;
      if (dueq.size() > 0 && dueq[0] == cyc) begin
        void'(dueq.pop_front());
        rvld = 1'b1;
        rdat = (rdq.size() > 0) ? rdq.pop_front() : 16'h0000;
      end
      if (wren0) begin wa0q.push_back(int'(wadr0)); wd0q.push_back(int'(wdat0)); end
      if (wren1) wa1q.push_back(int'(wadr1));
      if (rden0) begin
        ra0q.push_back(int'(radr0));
        last_rden_cyc = cyc;
        if (resp_en) dueq.push_back(cyc + 2);
      end
      if (rden1) ra1q.push_back(int'(radr1));
      if (tout0) begin tout_n++; tout_delta = cyc - last_rden_cyc; end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = bits[i];
      repeat (H) @(negedge clk);
      scl  = 1'b1;
      rx0  = {rx0[62:0], sdo0};
      rx1  = {rx1[62:0], sdo1};
      oel0 = {oel0[62:0], oe0};
      oel1 = {oel1[62:0], oe1};
      repeat (H) @(negedge clk);
      scl = 1'b0;
    end
  endtask

  task automatic frame(input logic [63:0] bits, input int n);
    rx0 = '0; rx1 = '0; oel0 = '0; oel1 = '0;
    csn = 1'b0;
    repeat (H) @(negedge clk);
    send_bits(bits, n);
    sdi = 1'b0;
    repeat (H) @(negedge clk);
    csn = 1'b1;
    repeat (4 * H) @(negedge clk);
  endtask

  task automatic clear_logs();
    wa0q.delete(); wd0q.delete(); wa1q.delete(); ra0q.delete(); ra1q.delete();
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out0", {wren0, wadr0, wdat0, rden0, radr0, sdo0, oe0, tout0}, 64'd0);
    chk("rst_out1", {wren1, wadr1, wdat1, rden1, radr1, sdo1, oe1, tout1}, 64'd0);
    chk("rst_state", 64'(dut0.state), 64'(ST_IDLE));

    // Single write 0x12 <= 0xBEEF, then 8 extra clocks that must be ignored
    frame({1'b1, 1'b0, 8'h12, 16'hBEEF, 8'hFF}, 34);
    chk("sw_count", wa0q.size(), 1);
    chk("sw_addr", wa0q[0], 8'h12);
    chk("sw_data", wd0q[0], 16'hBEEF);
    chk("sw_count_cpol1", wa1q.size(), 1);
    clear_logs();

    // Burst write from 0xFE, wrapping past 0xFF
    frame({1'b1, 1'b1, 8'hFE, 16'h0001, 16'h0002, 16'h0003}, 58);
    chk("bw_count", wa0q.size(), 3);
    chk("bw_addr0", wa0q[0], 8'hFE);
    chk("bw_addr1", wa0q[1], 8'hFF);
    chk("bw_addr2", wa0q[2], 8'h00);
    chk("bw_data", {wd0q[0][15:0], wd0q[1][15:0], wd0q[2][15:0]}, {16'h1, 16'h2, 16'h3});
    clear_logs();

    // Burst read from 0x10
    rdq.push_back(16'hA5A5); rdq.push_back(16'h5A5A); rdq.push_back(16'h0000);
    frame({1'b0, 1'b1, 8'h10, 32'h0}, 42);
    chk("br_sdo", rx0[31:0], 32'hA5A55A5A);
    chk("br_sdo_cpol1", rx1[31:0], 32'hA5A55A5A);
    chk("br_rden_count", ra0q.size(), 3);
    chk("br_radr", {ra0q[0][7:0], ra0q[1][7:0], ra0q[2][7:0]}, 24'h101112);
    chk("br_idle_sdo_oe", {sdo0, oe0}, 2'b00);
    clear_logs();

    // Partial write word: 7 of 16 bits, then CSN deasserted
    rx0 = '0; rx1 = '0;
    csn = 1'b0;
    repeat (H) @(negedge clk);
    send_bits({1'b1, 1'b0, 8'h20, 7'h55}, 17);
    repeat (H) @(negedge clk);
    csn = 1'b1;
    repeat (3) @(negedge clk);
    chk("part_idle", 64'(dut0.state), 64'(ST_IDLE));
    repeat (4 * H) @(negedge clk);
    chk("part_no_wren", wa0q.size(), 0);
    clear_logs();

    // Single read at 0x03: CPOL=0 and CPOL=1 instances side by side
    rdq.push_back(16'h1234);
    frame({1'b0, 1'b0, 8'h03, 16'h0}, 26);
    chk("cpol1_sdo", rx1[15:0], 16'h1234);
    chk("cpol0_sdo", rx0[15:0], 16'h1234);
    chk("cpol1_oe", oel1[25:0], 26'h000FFFF);
    chk("cpol0_oe", oel0[25:0], 26'h000FFFF);
    chk("cpol1_radr", {ra1q.size(), ra1q[0]}, {32'd1, 32'h03});
    chk("cpol1_oe_after", oe1, 1'b0);
    clear_logs();

    // Reset mid-frame: remainder of the frame is ignored until a fresh CSN fall
    csn = 1'b0;
    repeat (H) @(negedge clk);
    send_bits({1'b1, 1'b0, 3'b001}, 5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_bits({5'h1C, 16'h0F0F}, 21);
    repeat (H) @(negedge clk);
    csn = 1'b1;
    repeat (4 * H) @(negedge clk);
    chk("rstmid_no_wren", wa0q.size(), 0);
    frame({1'b1, 1'b0, 8'h3C, 16'h0F0F}, 26);
    chk("rstmid_next_frame", {wa0q.size(), wa0q[0], wd0q[0]}, {32'd1, 32'h3C, 32'h0F0F});
    clear_logs();

    // Read with no RVLD
    resp_en = 1'b0;
    frame({1'b0, 1'b0, 8'h40, 16'h0}, 26);
`ifdef SPI_BURST_SIF_TOUT_EN
    chk("tout_sdo", rx0[15:0], 16'hFFFF);
    chk("tout_pulses", tout_n, 1);
    chk("tout_delay", tout_delta, 15);
`else
    chk("nordy_sdo", rx0[15:0], 16'h0000);
    chk("nordy_tout", tout_n, 0);
`endif
    resp_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_sif.md
SPI_BURST_SIF -- requirements
Module: spi_burst_sif

Interface
REQ-001 SHALL have parameter P_ADDR_WIDTH, default 8, register address width (2..16).
REQ-002 SHALL have parameter P_DATA_WIDTH, default 16, register data width (2..32).
REQ-003 SHALL have parameter P_CPOL, default 0, SCL idle level; sample on leading edge, launch on trailing edge.
REQ-004 SHALL have parameter P_RD_TOUT, default 15, read-wait limit in CLK cycles.
REQ-005 SHALL have ports: CLK in 1, clock; RST in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: REG_WREN out 1, write strobe; REG_WADR out P_ADDR_WIDTH; REG_WDAT out P_DATA_WIDTH.
REQ-007 SHALL have ports: REG_RDEN out 1, read strobe; REG_RADR out P_ADDR_WIDTH; REG_RDAT in P_DATA_WIDTH; REG_RVLD in 1, read data valid.
REQ-008 SHALL have ports: SPI_CSN in 1; SPI_SCL in 1; SPI_SDI in 1; SPI_SDO out 1; SPI_SDO_OE out 1, SDO drive enable; RD_TOUT out 1, timeout pulse.

Function
REQ-009 SHALL synchronise CSN/SCL/SDI through one input register plus 2-stage shift; edges detected from shift stages.
REQ-010 SHALL frame as: bit RNW (1=write, 0=read), bit BURST, address MSB-first, then data words MSB-first.
REQ-011 SHALL use FSM IDLE -> CMD on CSN falling; CMD -> ADDR after 2 sample edges; ADDR -> DATA after P_ADDR_WIDTH sample edges; DATA -> HOLD after one word if BURST=0; HOLD ignores SCL.
REQ-012 SHALL return to IDLE one cycle after CSN deassert from any state; a partial word SHALL produce no strobe.
REQ-013 SHALL pulse REG_WREN one cycle, one CLK after the sample edge capturing the last bit of each write word, with REG_WADR/REG_WDAT valid in the same cycle.
REQ-014 SHALL, on read, pulse REG_RDEN one CLK after the last address bit, then (BURST=1) one CLK after the sample edge of each word's first bit, prefetching the next address.
REQ-015 SHALL increment word address after each word in burst, wrapping modulo 2^P_ADDR_WIDTH (all-ones -> 0).
REQ-016 SHALL load the SDO shift register on REG_RVLD; SHALL shift MSB-first on each launch edge in DATA read phase; SDO SHALL be 0 when not loaded.
REQ-017 SHALL assert SPI_SDO_OE only in DATA state with RNW=0; SPI_SDO registered (output-register packable).
REQ-018 SHALL ignore REG_RVLD when no read is outstanding; RVLD and RDEN in the same cycle SHALL service the older read.

Reset
REQ-019 SHALL reset all outputs to 0, FSM to IDLE, counters and shift registers to 0.
REQ-020 SHALL, on reset mid-frame, abandon the frame; next frame requires a fresh CSN falling edge.

Configuration
REQ-021 SHALL, with SPI_BURST_SIF_TOUT_EN defined, count P_RD_TOUT cycles from REG_RDEN; on expiry without RVLD load all-ones into SDO register and pulse RD_TOUT one cycle.
REQ-022 SHALL, without SPI_BURST_SIF_TOUT_EN, wait indefinitely for RVLD and tie RD_TOUT to 0.

Structure
REQ-023 SHALL place FSM state enum and frame-field constants (RNW/BURST bit positions) in package spi_sif_pkg.
REQ-024 SHALL implement the synchroniser and edge detector as sub-module spi_sif_sync; counters sized by $clog2.

Verification
REQ-025 Single write RNW=1,BURST=0, addr 0x12, data 0xBEEF -> one REG_WREN, WADR=0x12, WDAT=0xBEEF; extra SCL ignored.
REQ-026 Burst write addr 0xFE, 3 words 0x0001/0x0002/0x0003 -> WREN at addresses 0xFE, 0xFF, 0x00 with matching data.
REQ-027 Burst read addr 0x10, RVLD 2 cycles after each RDEN with 0xA5A5/0x5A5A -> SDO shows 0xA5A5 then 0x5A5A; RDEN at 0x10, 0x11, 0x12.
REQ-028 CSN raised after 7 of 16 write data bits -> no REG_WREN, FSM IDLE next cycle.
REQ-029 With SPI_BURST_SIF_TOUT_EN, read with no RVLD -> RD_TOUT pulse 15 cycles after RDEN, SDO shifts 0xFFFF.
REQ-030 P_CPOL=1, single read addr 0x03, RDAT 0x1234 -> correct capture with inverted SCL, SDO_OE high only in DATA.
